if_fetch_arbiter: RTL and testbench
===================================

// Module: if_fetch_arbiter
// PURPOSE
//  Shares one instruction-memory port among the SLOT_CNT IF slots driven by the pipeline manager.
//  Latches per-slot fetch requests (if_en/if_pc), arbitrates round-robin and issues ready/valid requests.
//  Tracks in-flight fetches in an in-order tag FIFO. Returns each live response to its slot.
//  Discards responses for killed or superseded fetches.
// PARAMETERS
//  SLOT_CNT   4   requesting IF slots (= core::peval_width ** 2); >= 1
//  MAX_OUT    2   max accepted-but-unanswered memory requests (tag FIFO depth); >= 1
//  ADDR_W     32  width of sys::addr_t
//  INST_W     32  instruction word width
// PORTS
//  clk             in   1                clock
//  rst             in   1                reset, synchronous, active-high (bool_t)
//  slot_req_valid  in   SLOT_CNT         new fetch request per slot (from if_en)
//  slot_req_pc     in   SLOT_CNTxADDR_W  fetch address per slot (from if_pc), word aligned
//  slot_kill       in   SLOT_CNT         drop pending and in-flight fetch of slot (from if_rst)
//  slot_rsp_valid  out  SLOT_CNT         one-cycle pulse: instruction returned for slot
//  slot_rsp_inst   out  SLOT_CNTxINST_W  returned instruction; valid only with slot_rsp_valid
//  slot_busy       out  SLOT_CNT         slot has a pending or live in-flight fetch
//  mem_req_valid   out  1                memory request valid
//  mem_req_addr    out  ADDR_W           memory request address
//  mem_req_ready   in   1                memory accepts request this cycle
//  mem_rsp_valid   in   1                memory response valid (in order, always accepted)
//  mem_rsp_data    in   INST_W           memory response data
//  rsp_err         out  1                sticky: mem_rsp_valid seen with tag FIFO empty
// BEHAVIOUR
//  Reset (rst high at posedge):
//  - All pending flags cleared; tag FIFO emptied; rr pointer = 0.
//  - mem_req_valid=0, mem_req_addr=0, slot_rsp_valid=0, slot_rsp_inst=0, rsp_err=0.
//  - Reset mid-transaction abandons everything. A later mem_rsp_valid with an empty FIFO sets rsp_err.
//  Per-slot state: pending flag + pc; live in-flight = any FIFO entry with slot==s and live==1.
//  - At most one live fetch per slot. slot_busy = pending | live in-flight (combinational from regs).
//  Per-slot request capture (registered, one cycle):
//  - slot_req_valid: pending<=1, pc<=slot_req_pc. Overwrites an unissued pending pc.
//  - Same cycle, all FIFO entries of that slot get live<=0 (supersede).
//  - slot_kill without req: pending<=0, FIFO entries of slot live<=0.
//  - kill+req same cycle: kill applied first, then the new request becomes pending.
//  Issue FSM, states IDLE/REQ:
//  - IDLE: if any pending and FIFO not full, select the first pending slot at or after rr (wrapping).
//    Drive mem_req_valid=1, mem_req_addr=its pc next cycle, clear its pending flag; go to REQ.
//  - REQ: valid and addr held stable until mem_req_ready. No re-arbitration, even if the slot is
//    killed or re-requested.
//  - On valid&&ready: push {slot, live} to FIFO; rr<=slot+1 mod SLOT_CNT.
//  - live=0 if the slot was killed or re-requested while in REQ (covers the accept cycle too).
//  - On accept: if another pending slot and FIFO not full after push, issue back-to-back (stay REQ,
//    new addr next cycle); else IDLE.
//  - Minimum latency: req in cycle N -> mem_req_valid in N+1.
//  Response path:
//  - mem_rsp_valid pops FIFO head. If live: next cycle slot_rsp_valid[slot]=1, slot_rsp_inst[slot]=data.
//    If not live: dropped silently.
//  - Push and pop in the same cycle: both happen; occupancy unchanged.
//  - A full FIFO with a simultaneous pop permits no push that cycle; issue waits.
//  - Pop that cycle with a kill of the head's slot: the response is dropped (kill wins).
// TESTING
//  - Reset: rst=1 for 2 cycles with slot_req_valid=4'hF. Outputs all 0; no mem_req_valid until 1 cycle
//    after rst falls.
//  - Single fetch: slot2 req pc=0x100, ready=1, rsp 3 cycles later data=0x00000013.
//    Expect mem_req_addr=0x100, then slot_rsp_valid=4'b0100 with inst 0x13.
//  - Round-robin: slots 0,1,3 req at once, ready=1. Issue order 0x0,0x4,0xC on consecutive-capable
//    cycles, bounded by MAX_OUT=2; responses routed 1:1.
//  - Stall hold: ready=0 for 5 cycles with slot1 killed meanwhile. Addr held stable; after accept,
//    response dropped; slot_rsp_valid stays 0.
//  - Supersede: slot0 in flight to 0x200; slot0 re-requests 0x300. First response dropped; second
//    delivers data for 0x300.
//  - Error: mem_rsp_valid with FIFO empty sets rsp_err=1 and holds it until rst.

Source files
------------

// File: rtl/if_fetch_arbiter.sv
// Round-robin share of one instruction-memory port among SLOT_CNT fetch slots; issue is registered (request -> mem_req_valid next cycle).
// In-order tag FIFO routes each response to its slot or drops it when the fetch was killed/superseded; issue stalls on a full FIFO or !mem_req_ready.
module if_fetch_arbiter #(
   parameter int SLOT_CNT = 4,
   parameter int MAX_OUT  = 2,
   parameter int ADDR_W   = 32,
   parameter int INST_W   = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [SLOT_CNT-1:0]             slot_req_valid,
   input  logic [SLOT_CNT-1:0][ADDR_W-1:0] slot_req_pc,
   input  logic [SLOT_CNT-1:0]             slot_kill,
   output logic [SLOT_CNT-1:0]             slot_rsp_valid,
   output logic [SLOT_CNT-1:0][INST_W-1:0] slot_rsp_inst,
   output logic [SLOT_CNT-1:0]             slot_busy,
   output logic                            mem_req_valid,
   output logic [ADDR_W-1:0]               mem_req_addr,
   input  logic                            mem_req_ready,
   input  logic                            mem_rsp_valid,
   input  logic [INST_W-1:0]               mem_rsp_data,
   output logic                            rsp_err
);
   localparam int SW = (SLOT_CNT > 1) ? $clog2(SLOT_CNT) : 1;
   localparam int FW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int CW = $clog2(MAX_OUT + 1);
   localparam logic [SW-1:0] LAST_SLOT = SW'(SLOT_CNT - 1);
   localparam logic [FW-1:0] LAST_ENT  = FW'(MAX_OUT - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(MAX_OUT);

   typedef enum logic {ST_IDLE, ST_REQ} state_t;

   state_t                          r_state, w_state_nxt;
   logic [SLOT_CNT-1:0]             r_pend, w_pend_eff, w_pend_nxt, w_drop;
   logic [SLOT_CNT-1:0][ADDR_W-1:0] r_pc, w_pc_eff;
   logic                            r_req_vld, r_req_live;
   logic [ADDR_W-1:0]               r_req_addr;
   logic [SW-1:0]                   r_req_slot, r_rr, w_rr_base, w_slot_inc, w_sel, w_head_slot;
   logic [SW:0]                     w_sum;
   logic                            w_found, w_issue, w_accept, w_pop, w_push_live, w_head_live;
   logic [SW-1:0]                   r_fslot [MAX_OUT];
   logic [MAX_OUT-1:0]              r_flive;
   logic [FW-1:0]                   r_rd, r_wr;
   logic [CW-1:0]                   r_cnt, w_cnt_nxt;
   logic [SLOT_CNT-1:0]             r_rsp_vld, w_busy;
   logic [SLOT_CNT-1:0][INST_W-1:0] r_rsp_inst;
   logic                            r_err;

   // A kill or a new request both end any outstanding fetch of that slot.
   assign w_drop      = slot_kill | slot_req_valid;
   assign w_pend_eff  = (r_pend & ~slot_kill) | slot_req_valid;
   assign w_accept    = r_req_vld & mem_req_ready;
   assign w_pop       = mem_rsp_valid & (r_cnt != '0);
   assign w_cnt_nxt   = r_cnt + CW'(w_accept) - CW'(w_pop);
   assign w_push_live = r_req_live & ~w_drop[r_req_slot];
   assign w_head_slot = r_fslot[r_rd];
   assign w_head_live = r_flive[r_rd] & ~w_drop[w_head_slot];
   assign w_slot_inc  = (r_req_slot == LAST_SLOT) ? '0 : r_req_slot + 1'b1;
   assign w_rr_base   = w_accept ? w_slot_inc : r_rr;

   always_comb begin
      w_pc_eff = r_pc;
      for (int s = 0; s < SLOT_CNT; s++)
         if (slot_req_valid[s]) w_pc_eff[s] = slot_req_pc[s];
   end

   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_sum   = '0;
      for (int i = 0; i < SLOT_CNT; i++) begin
         w_sum = {1'b0, w_rr_base} + (SW+1)'(i);
         if (w_sum >= (SW+1)'(SLOT_CNT)) w_sum = w_sum - (SW+1)'(SLOT_CNT);
         if (!w_found && w_pend_eff[w_sum[SW-1:0]]) begin
            w_found = 1'b1;
            w_sel   = w_sum[SW-1:0];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      case (r_state)
         ST_IDLE: if (w_found && r_cnt < FULL_CNT) begin
            w_issue     = 1'b1;
            w_state_nxt = ST_REQ;
         end
         ST_REQ: if (w_accept) begin
            if (w_found && w_cnt_nxt < FULL_CNT) w_issue = 1'b1;
            else                                 w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_pend_nxt = w_pend_eff & ~(w_issue ? (SLOT_CNT'(1) << w_sel) : '0);

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend     <= '0;
         r_pc       <= '0;
         r_req_vld  <= 1'b0;
         r_req_addr <= '0;
         r_req_slot <= '0;
         r_req_live <= 1'b0;
         r_rr       <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         r_pc   <= w_pc_eff;
         if (w_accept) r_rr <= w_slot_inc;
         if (w_issue) begin
            r_req_vld  <= 1'b1;
            r_req_addr <= w_pc_eff[w_sel];
            r_req_slot <= w_sel;
            r_req_live <= 1'b1;
         end else if (w_accept) begin
            r_req_vld  <= 1'b0;
         end else if (r_req_vld) begin
            r_req_live <= r_req_live & ~w_drop[r_req_slot];
         end
      end
   end

   // Popped entries are cleared so a set live bit always marks an occupied entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int e = 0; e < MAX_OUT; e++) r_fslot[e] <= '0;
         r_flive <= '0;
         r_rd    <= '0;
         r_wr    <= '0;
         r_cnt   <= '0;
      end else begin
         for (int e = 0; e < MAX_OUT; e++)
            if (w_drop[r_fslot[e]]) r_flive[e] <= 1'b0;
         if (w_pop) begin
            r_flive[r_rd] <= 1'b0;
            r_rd <= (r_rd == LAST_ENT) ? '0 : r_rd + 1'b1;
         end
         if (w_accept) begin
            r_fslot[r_wr] <= r_req_slot;
            r_flive[r_wr] <= w_push_live;
            r_wr <= (r_wr == LAST_ENT) ? '0 : r_wr + 1'b1;
         end
         r_cnt <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_vld  <= '0;
         r_rsp_inst <= '0;
         r_err      <= 1'b0;
      end else begin
         r_rsp_vld <= '0;
         if (w_pop && w_head_live) begin
            r_rsp_vld[w_head_slot]  <= 1'b1;
            r_rsp_inst[w_head_slot] <= mem_rsp_data;
         end
         if (mem_rsp_valid && r_cnt == '0) r_err <= 1'b1;
      end
   end

   always_comb begin
      w_busy = r_pend;
      for (int s = 0; s < SLOT_CNT; s++) begin
         if (r_req_vld && r_req_live && r_req_slot == SW'(s)) w_busy[s] = 1'b1;
         for (int e = 0; e < MAX_OUT; e++)
            if (r_flive[e] && r_fslot[e] == SW'(s)) w_busy[s] = 1'b1;
      end
   end

   assign slot_busy      = w_busy;
   assign slot_rsp_valid = r_rsp_vld;
   assign slot_rsp_inst  = r_rsp_inst;
   assign mem_req_valid  = r_req_vld;
   assign mem_req_addr   = r_req_addr;
   assign rsp_err        = r_err;
endmodule

// File: tb/tb_if_fetch_arbiter.sv
// Self-checking bench for if_fetch_arbiter: directed vector table, multi-cycle corner sequences,
// then randomized traffic scored against a per-slot "latest request wins" model.
module tb_if_fetch_arbiter;
   localparam int SLOT_CNT = 4;
   localparam int MAX_OUT  = 2;
   localparam int ADDR_W   = 32;
   localparam int INST_W   = 32;

   logic                            clk = 1'b0;
   logic                            rst;
   logic [SLOT_CNT-1:0]             slot_req_valid;
   logic [SLOT_CNT-1:0][ADDR_W-1:0] slot_req_pc;
   logic [SLOT_CNT-1:0]             slot_kill;
   logic [SLOT_CNT-1:0]             slot_rsp_valid;
   logic [SLOT_CNT-1:0][INST_W-1:0] slot_rsp_inst;
   logic [SLOT_CNT-1:0]             slot_busy;
   logic                            mem_req_valid;
   logic [ADDR_W-1:0]               mem_req_addr;
   logic                            mem_req_ready;
   logic                            mem_rsp_valid;
   logic [INST_W-1:0]               mem_rsp_data;
   logic                            rsp_err;

   if_fetch_arbiter #(.SLOT_CNT(SLOT_CNT), .MAX_OUT(MAX_OUT), .ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
      .clk(clk), .rst(rst),
      .slot_req_valid(slot_req_valid), .slot_req_pc(slot_req_pc), .slot_kill(slot_kill),
      .slot_rsp_valid(slot_rsp_valid), .slot_rsp_inst(slot_rsp_inst), .slot_busy(slot_busy),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic nstep(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic idle_inputs();
      slot_req_valid = '0;
      slot_req_pc    = '0;
      slot_kill      = '0;
      mem_req_ready  = 1'b1;
      mem_rsp_valid  = 1'b0;
      mem_rsp_data   = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      nstep(2);
      rst = 1'b0;
   endtask

   function automatic logic [31:0] rdata(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   typedef struct {
      int          slot;
      logic [31:0] pc;
      logic [31:0] data;
      bit          kill;
      logic [3:0]  exp_vld;
   } vec_t;

   vec_t vt[4];

   logic [31:0] mq[$];
   logic [31:0] cur_pc[SLOT_CNT];
   bit          cur_v[SLOT_CNT];
   logic [31:0] del_pc[SLOT_CNT];
   bit          del_v[SLOT_CNT];
   logic [31:0] exp_inst[SLOT_CNT];
   logic [3:0]  exp_vld;
   bit          hold, drain, pop, accept;
   logic [31:0] hold_addr, a, p;
   int          sl, seq;

   initial begin
      vt[0] = '{slot: 2, pc: 32'h0000_0100, data: 32'h0000_0013, kill: 1'b0, exp_vld: 4'b0100};
      vt[1] = '{slot: 0, pc: 32'h0000_0040, data: 32'hDEAD_BEEF, kill: 1'b0, exp_vld: 4'b0001};
      vt[2] = '{slot: 3, pc: 32'hFFFF_FFFC, data: 32'h1234_5678, kill: 1'b0, exp_vld: 4'b1000};
      vt[3] = '{slot: 1, pc: 32'h0000_0080, data: 32'hAAAA_5555, kill: 1'b1, exp_vld: 4'b0000};

      // Reset with all slots requesting: nothing may be latched.
      idle_inputs();
      rst = 1'b1;
      slot_req_valid = 4'hF;
      slot_req_pc = {32'h30, 32'h20, 32'h10, 32'h00};
      nstep(2);
      chk("rst_rsp_vld", slot_rsp_valid, 0);
      chk("rst_rsp_inst_zero", slot_rsp_inst == '0, 1);
      chk("rst_req_vld", mem_req_valid, 0);
      chk("rst_req_addr", mem_req_addr, 0);
      chk("rst_err", rsp_err, 0);
      chk("rst_busy", slot_busy, 0);
      rst = 1'b0;
      slot_req_valid = '0;
      nstep(1);
      chk("rst_after_req_vld", mem_req_valid, 0);

      // Single fetches from the vector table.
      for (int i = 0; i < 4; i++) begin
         idle_inputs();
         slot_req_valid[vt[i].slot] = 1'b1;
         slot_req_pc[vt[i].slot]    = vt[i].pc;
         nstep(1);
         slot_req_valid = '0;
         chk("tbl_req_vld", mem_req_valid, 1);
         chk("tbl_req_addr", mem_req_addr, vt[i].pc);
         if (vt[i].kill) slot_kill[vt[i].slot] = 1'b1;
         nstep(1);
         slot_kill = '0;
         chk("tbl_req_done", mem_req_valid, 0);
         chk("tbl_busy_inflight", slot_busy, vt[i].exp_vld);
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = vt[i].data;
         nstep(1);
         mem_rsp_valid = 1'b0;
         chk("tbl_rsp_vld", slot_rsp_valid, vt[i].exp_vld);
         if (vt[i].exp_vld != 0) chk("tbl_rsp_inst", slot_rsp_inst[vt[i].slot], vt[i].data);
         chk("tbl_busy_after", slot_busy, 0);
         nstep(1);
         chk("tbl_rsp_pulse", slot_rsp_valid, 0);
      end

      // Round-robin over slots 0,1,3 with the FIFO limiting to two outstanding.
      do_reset();
      slot_req_valid = 4'b1011;
      slot_req_pc[0] = 32'h0; slot_req_pc[1] = 32'h4; slot_req_pc[3] = 32'hC;
      nstep(1);
      slot_req_valid = '0;
      chk("rr_vld0", mem_req_valid, 1);
      chk("rr_addr0", mem_req_addr, 32'h0);
      nstep(1);
      chk("rr_vld1", mem_req_valid, 1);
      chk("rr_addr1", mem_req_addr, 32'h4);
      nstep(1);
      chk("rr_full_stall", mem_req_valid, 0);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA000_0000;
      nstep(1);
      chk("rr_rsp0_vld", slot_rsp_valid, 4'b0001);
      chk("rr_rsp0_inst", slot_rsp_inst[0], 32'hA000_0000);
      chk("rr_pop_no_issue", mem_req_valid, 0);
      mem_rsp_data = 32'hA000_0001;
      nstep(1);
      mem_rsp_valid = 1'b0;
      chk("rr_rsp1_vld", slot_rsp_valid, 4'b0010);
      chk("rr_rsp1_inst", slot_rsp_inst[1], 32'hA000_0001);
      chk("rr_vld3", mem_req_valid, 1);
      chk("rr_addr3", mem_req_addr, 32'hC);
      nstep(1);
      chk("rr_vld_done", mem_req_valid, 0);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA000_0003;
      nstep(1);
      mem_rsp_valid = 1'b0;
      chk("rr_rsp3_vld", slot_rsp_valid, 4'b1000);
      chk("rr_rsp3_inst", slot_rsp_inst[3], 32'hA000_0003);

      // Stall hold with a kill while the request waits for ready.
      idle_inputs();
      mem_req_ready = 1'b0;
      slot_req_valid[1] = 1'b1; slot_req_pc[1] = 32'h500;
      nstep(1);
      slot_req_valid = '0;
      chk("stall_vld", mem_req_valid, 1);
      for (int i = 0; i < 5; i++) begin
         slot_kill = (i == 2) ? 4'b0010 : 4'b0000;
         nstep(1);
         chk("stall_hold_vld", mem_req_valid, 1);
         chk("stall_hold_addr", mem_req_addr, 32'h500);
      end
      slot_kill = '0;
      mem_req_ready = 1'b1;
      nstep(1);
      chk("stall_accepted", mem_req_valid, 0);
      chk("stall_busy_dead", slot_busy, 0);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_0000;
      nstep(1);
      mem_rsp_valid = 1'b0;
      chk("stall_rsp_dropped", slot_rsp_valid, 0);
      chk("stall_no_err", rsp_err, 0);

      // Supersede: slot0 re-requests while its first fetch is in the FIFO.
      idle_inputs();
      slot_req_valid[0] = 1'b1; slot_req_pc[0] = 32'h200;
      nstep(1);
      slot_req_valid = '0;
      chk("sup_addr_a", mem_req_addr, 32'h200);
      nstep(1);
      slot_req_valid[0] = 1'b1; slot_req_pc[0] = 32'h300;
      nstep(1);
      slot_req_valid = '0;
      chk("sup_vld_b", mem_req_valid, 1);
      chk("sup_addr_b", mem_req_addr, 32'h300);
      nstep(1);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0200;
      nstep(1);
      chk("sup_first_dropped", slot_rsp_valid, 0);
      mem_rsp_data = 32'h0000_0300;
      nstep(1);
      mem_rsp_valid = 1'b0;
      chk("sup_second_vld", slot_rsp_valid, 4'b0001);
      chk("sup_second_inst", slot_rsp_inst[0], 32'h0000_0300);

      // Response with an empty FIFO is sticky until reset, including after an abandoned fetch.
      idle_inputs();
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_0000;
      nstep(1);
      mem_rsp_valid = 1'b0;
      chk("err_set", rsp_err, 1);
      chk("err_no_rsp", slot_rsp_valid, 0);
      nstep(3);
      chk("err_sticky", rsp_err, 1);
      slot_req_valid[2] = 1'b1; slot_req_pc[2] = 32'h700;
      nstep(1);
      slot_req_valid = '0;
      chk("abandon_vld", mem_req_valid, 1);
      rst = 1'b1;
      nstep(1);
      rst = 1'b0;
      chk("abandon_err_clr", rsp_err, 0);
      chk("abandon_req_clr", mem_req_valid, 0);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0700;
      nstep(1);
      mem_rsp_valid = 1'b0;
      chk("abandon_err", rsp_err, 1);
      chk("abandon_no_rsp", slot_rsp_valid, 0);

      // Randomized traffic: a fetch is delivered iff its pc is still the slot's latest request.
      do_reset();
      for (int s = 0; s < SLOT_CNT; s++) begin
         cur_v[s] = 1'b0; del_v[s] = 1'b0; cur_pc[s] = '0; del_pc[s] = '0; exp_inst[s] = '0;
      end
      exp_vld = '0;
      hold = 1'b0;
      hold_addr = '0;
      seq = 1;
      for (int cyc = 0; cyc < 3040; cyc++) begin
         drain = (cyc >= 3000);
         chk("rnd_rsp_vld", slot_rsp_valid, exp_vld);
         for (int s = 0; s < SLOT_CNT; s++)
            if (exp_vld[s]) chk("rnd_rsp_inst", slot_rsp_inst[s], exp_inst[s]);
         if (hold) begin
            chk("rnd_hold_vld", mem_req_valid, 1);
            chk("rnd_hold_addr", mem_req_addr, hold_addr);
         end
         slot_req_valid = '0;
         slot_kill = '0;
         for (int s = 0; s < SLOT_CNT; s++) begin
            if (!drain) begin
               if ($urandom_range(0, 99) < 6) slot_kill[s] = 1'b1;
               if ($urandom_range(0, 99) < 15) begin
                  p = (32'(seq) << 4) | (32'(s) << 2);
                  slot_req_valid[s] = 1'b1;
                  slot_req_pc[s] = p;
                  seq++;
               end
            end
         end
         mem_req_ready = drain ? 1'b1 : ($urandom_range(0, 99) < 60);
         pop = (mq.size() > 0) && (drain || $urandom_range(0, 99) < 50);
         mem_rsp_valid = pop;
         mem_rsp_data = pop ? rdata(mq[0]) : $urandom;
         accept = mem_req_valid && mem_req_ready;
         for (int s = 0; s < SLOT_CNT; s++) begin
            if (slot_kill[s]) cur_v[s] = 1'b0;
            if (slot_req_valid[s]) begin
               cur_v[s] = 1'b1;
               cur_pc[s] = slot_req_pc[s];
            end
         end
         exp_vld = '0;
         if (pop) begin
            a = mq.pop_front();
            sl = int'(a[3:2]);
            if (cur_v[sl] && cur_pc[sl] == a) begin
               exp_vld[sl] = 1'b1;
               exp_inst[sl] = rdata(a);
               del_pc[sl] = a;
               del_v[sl] = 1'b1;
            end
         end
         if (accept) begin
            chk("rnd_outstanding", mq.size() < MAX_OUT, 1);
            mq.push_back(mem_req_addr);
         end
         hold = mem_req_valid && !mem_req_ready;
         hold_addr = mem_req_addr;
         @(negedge clk);
      end
      chk("drain_busy", slot_busy, 0);
      chk("drain_req_vld", mem_req_valid, 0);
      chk("drain_err", rsp_err, 0);
      for (int s = 0; s < SLOT_CNT; s++) begin
         if (cur_v[s]) begin
            chk("drain_delivered", del_v[s], 1);
            chk("drain_latest_pc", del_pc[s], cur_pc[s]);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
